// File: rtl/wb_queue_pkg.sv
// ============================================================================
// Module : wb_queue_pkg
// Brief  : Shared types and constants for the register-file write-back queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_queue_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_queue_mem.sv
// ============================================================================
// Module : wb_queue_mem
// Brief  : DEPTH-entry write-back storage, one write and one read port, with
//          every entry and its valid bit exposed for the forwarding search.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_queue_mem
    import wb_queue_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en_i,
    input  logic [PW-1:0]                        wr_idx_i,
    input  logic [WB_ADDR_W-1:0]                 wr_addr_i,
    input  logic [N-1:0]                         wr_data_i,
    input  logic                                 rd_en_i,
    input  logic [PW-1:0]                        rd_idx_i,
    output logic [WB_ADDR_W-1:0]                 rd_addr_o,
    output logic [N-1:0]                         rd_data_o,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]      entry_addr_o,
    output logic [DEPTH-1:0][N-1:0]              entry_data_o,
    output logic [DEPTH-1:0]                     valid_o
);

    logic [DEPTH-1:0][WB_ADDR_W-1:0] addr_d, addr_q;
    logic [DEPTH-1:0][N-1:0]         data_d, data_q;
    logic [DEPTH-1:0]                valid_d, valid_q;

    // Read clears before write sets; the top never writes and reads one slot
    // at the same edge, so the order only matters for clarity.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (rd_en_i) begin
            valid_d[rd_idx_i] = 1'b0;
        end
        if (wr_en_i) begin
            addr_d[wr_idx_i]  = wr_addr_i;
            data_d[wr_idx_i]  = wr_data_i;
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rd_addr_o    = addr_q[rd_idx_i];
    assign rd_data_o    = data_q[rd_idx_i];
    assign entry_addr_o = addr_q;
    assign entry_data_o = data_q;
    assign valid_o      = valid_q;

endmodule

`default_nettype wire

// File: rtl/writeback_queue.sv
// ============================================================================
// Module : writeback_queue
// Brief  : In-order write-back buffer feeding the register file write port,
//          with optional same-cycle forwarding (macro WB_QUEUE_FORWARD_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_queue
    import wb_queue_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     In_Valid_i,
    output logic                     In_Ready_o,
    input  logic [4:0]               In_Register_i,
    input  logic [N-1:0]             In_Data_i,
    input  logic                     Drain_En_i,
    output logic                     Reg_Write_o,
    output logic [4:0]               Write_Register_o,
    output logic [N-1:0]             Write_Data_o,
    output logic [$clog2(DEPTH):0]   Count_o,
    input  logic [4:0]               Fwd_Addr_1_i,
    input  logic [4:0]               Fwd_Addr_2_i,
    output logic                     Fwd_Hit_1_o,
    output logic                     Fwd_Hit_2_o,
    output logic [N-1:0]             Fwd_Data_1_o,
    output logic [N-1:0]             Fwd_Data_2_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]          wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]          rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]          count_d, count_q;
    logic                   reg_write_d, reg_write_q;
    logic [WB_ADDR_W-1:0]   write_register_d, write_register_q;
    logic [N-1:0]           write_data_d, write_data_q;

    logic                   push, pop;
    logic [WB_ADDR_W-1:0]   head_addr;
    logic [N-1:0]           head_data;
    logic [DEPTH-1:0][WB_ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][N-1:0]         ent_data;
    logic [DEPTH-1:0]                ent_valid;

    // Ready depends on stored count only, so a pop never opens a full queue early.
    assign In_Ready_o = (count_q < FULL_COUNT);
    assign push       = In_Valid_i && In_Ready_o && (In_Register_i != REG_ZERO);
    assign pop        = Drain_En_i && (count_q != '0);

    wb_queue_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (push),
        .wr_idx_i     (wr_ptr_q),
        .wr_addr_i    (In_Register_i),
        .wr_data_i    (In_Data_i),
        .rd_en_i      (pop),
        .rd_idx_i     (rd_ptr_q),
        .rd_addr_o    (head_addr),
        .rd_data_o    (head_data),
        .entry_addr_o (ent_addr),
        .entry_data_o (ent_data),
        .valid_o      (ent_valid)
    );

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        reg_write_d      = pop;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d         = rd_ptr_q + PW'(1);
            write_register_d = head_addr;
            write_data_d     = head_data;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign Reg_Write_o      = reg_write_q;
    assign Write_Register_o = write_register_q;
    assign Write_Data_o     = write_data_q;
    assign Count_o          = count_q;

`ifdef WB_QUEUE_FORWARD_EN
    // Walk oldest to newest so later matches override: newest entry wins,
    // the output stage only wins when no queued entry matches.
    function automatic logic [N:0] fwd_lookup(input logic [WB_ADDR_W-1:0] addr);
        logic [N:0]    res;
        logic [PW-1:0] idx;
        res = '0;
        if (addr != REG_ZERO) begin
            if (reg_write_q && (write_register_q == addr)) begin
                res = {1'b1, write_data_q};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if (ent_valid[idx] && (ent_addr[idx] == addr)) begin
                    res = {1'b1, ent_data[idx]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {Fwd_Hit_1_o, Fwd_Data_1_o} = fwd_lookup(Fwd_Addr_1_i);
        {Fwd_Hit_2_o, Fwd_Data_2_o} = fwd_lookup(Fwd_Addr_2_i);
    end
`else
    logic unused_fwd;
    assign unused_fwd   = ^{Fwd_Addr_1_i, Fwd_Addr_2_i, ent_addr, ent_data, ent_valid};
    assign Fwd_Hit_1_o  = 1'b0;
    assign Fwd_Hit_2_o  = 1'b0;
    assign Fwd_Data_1_o = '0;
    assign Fwd_Data_2_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ============================================================================
// Module : tb_writeback_queue
// Brief  : Directed self-checking bench for writeback_queue (N=32, DEPTH=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_queue;

`ifdef WB_QUEUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        In_Valid_i;
    logic        In_Ready_o;
    logic [4:0]  In_Register_i;
    logic [31:0] In_Data_i;
    logic        Drain_En_i;
    logic        Reg_Write_o;
    logic [4:0]  Write_Register_o;
    logic [31:0] Write_Data_o;
    logic [2:0]  Count_o;
    logic [4:0]  Fwd_Addr_1_i;
    logic [4:0]  Fwd_Addr_2_i;
    logic        Fwd_Hit_1_o;
    logic        Fwd_Hit_2_o;
    logic [31:0] Fwd_Data_1_o;
    logic [31:0] Fwd_Data_2_o;

    int n_assert;
    int n_fail;

    writeback_queue #(.N(32), .DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .In_Valid_i       (In_Valid_i),
        .In_Ready_o       (In_Ready_o),
        .In_Register_i    (In_Register_i),
        .In_Data_i        (In_Data_i),
        .Drain_En_i       (Drain_En_i),
        .Reg_Write_o      (Reg_Write_o),
        .Write_Register_o (Write_Register_o),
        .Write_Data_o     (Write_Data_o),
        .Count_o          (Count_o),
        .Fwd_Addr_1_i     (Fwd_Addr_1_i),
        .Fwd_Addr_2_i     (Fwd_Addr_2_i),
        .Fwd_Hit_1_o      (Fwd_Hit_1_o),
        .Fwd_Hit_2_o      (Fwd_Hit_2_o),
        .Fwd_Data_1_o     (Fwd_Data_1_o),
        .Fwd_Data_2_o     (Fwd_Data_2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] rw,
                           input logic [31:0] rg, input logic [31:0] dat);
        chk({tag, "_rw"},   32'(Reg_Write_o),      rw);
        chk({tag, "_reg"},  32'(Write_Register_o), rg);
        chk({tag, "_data"}, Write_Data_o,          dat);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        In_Valid_i    = v;
        In_Register_i = r;
        In_Data_i     = d;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        Drain_En_i    = 1'b0;
        Fwd_Addr_1_i  = 5'd0;
        Fwd_Addr_2_i  = 5'd0;
        drive(1'b0, 5'd0, 32'd0);

        // Reset state
        #2;
        chk("rst_count", 32'(Count_o), 0);
        chk_out("rst", 0, 0, 0);
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(In_Ready_o), 1);
        chk("rst_count2", 32'(Count_o), 0);

        // 1. Reset while draining
        drive(1'b1, 5'd3, 32'd30); tick;
        drive(1'b1, 5'd5, 32'd50); tick;
        drive(1'b1, 5'd6, 32'd60); tick;
        drive(1'b0, 5'd0, 32'd0);
        chk("t1_count3", 32'(Count_o), 3);
        Drain_En_i = 1'b1;
        tick;
        chk_out("t1_drain", 1, 3, 30);
        chk("t1_count2", 32'(Count_o), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_async_count", 32'(Count_o), 0);
        chk_out("t1_async", 0, 0, 0);
        tick;
        reset = 1'b1;
        #1;
        chk("t1_ready", 32'(In_Ready_o), 1);
        tick;
        chk("t1_discard_rw", 32'(Reg_Write_o), 0);
        chk("t1_discard_count", 32'(Count_o), 0);
        Drain_En_i = 1'b0;

        // 2. Order and latency
        Drain_En_i = 1'b1;
        drive(1'b1, 5'd2, 32'd7); tick;
        chk("t2_lat_rw", 32'(Reg_Write_o), 0);
        chk("t2_lat_count", 32'(Count_o), 1);
        drive(1'b1, 5'd4, 32'd20); tick;
        chk_out("t2_o1", 1, 2, 7);
        drive(1'b1, 5'd25, 32'd6); tick;
        chk_out("t2_o2", 1, 4, 20);
        drive(1'b0, 5'd0, 32'd0); tick;
        chk_out("t2_o3", 1, 25, 6);
        chk("t2_count0", 32'(Count_o), 0);
        tick;
        chk_out("t2_idle", 0, 25, 6);
        Drain_En_i = 1'b0;

        // 3. Full queue, no bypass, one slot freed per cycle
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(10 + i));
            tick;
        end
        chk("t3_count4", 32'(Count_o), 4);
        chk("t3_ready0", 32'(In_Ready_o), 0);
        drive(1'b1, 5'd5, 32'd15);
        tick;
        chk("t3_rej_count", 32'(Count_o), 4);
        Drain_En_i = 1'b1;
        #1;
        chk("t3_nobypass", 32'(In_Ready_o), 0);
        tick;
        drive(1'b0, 5'd0, 32'd0);
        chk_out("t3_d1", 1, 1, 11);
        chk("t3_c3", 32'(Count_o), 3);
        chk("t3_ready1", 32'(In_Ready_o), 1);
        tick;
        chk_out("t3_d2", 1, 2, 12);
        chk("t3_c2", 32'(Count_o), 2);
        tick;
        chk_out("t3_d3", 1, 3, 13);
        chk("t3_c1", 32'(Count_o), 1);
        tick;
        chk_out("t3_d4", 1, 4, 14);
        chk("t3_c0", 32'(Count_o), 0);
        tick;
        chk("t3_empty_rw", 32'(Reg_Write_o), 0);
        Drain_En_i = 1'b0;

        // 4. Register 0 is accepted but dropped
        drive(1'b1, 5'd0, 32'd3);
        #1;
        chk("t4_ready_r0", 32'(In_Ready_o), 1);
        tick;
        chk("t4_count_r0", 32'(Count_o), 0);
        drive(1'b1, 5'd31, 32'd78); tick;
        chk("t4_count1", 32'(Count_o), 1);
        drive(1'b0, 5'd0, 32'd0);
        Drain_En_i = 1'b1;
        tick;
        chk_out("t4_w", 1, 31, 78);
        tick;
        chk("t4_only_one", 32'(Reg_Write_o), 0);
        Drain_En_i = 1'b0;

        // 5. Simultaneous push and pop at count 2
        drive(1'b1, 5'd6, 32'd60); tick;
        drive(1'b1, 5'd7, 32'd70); tick;
        chk("t5_c2", 32'(Count_o), 2);
        Drain_En_i = 1'b1;
        drive(1'b1, 5'd8, 32'd80);   tick;
        chk_out("t5_p1", 1, 6, 60);  chk("t5_c_a", 32'(Count_o), 2);
        drive(1'b1, 5'd9, 32'd90);   tick;
        chk_out("t5_p2", 1, 7, 70);  chk("t5_c_b", 32'(Count_o), 2);
        drive(1'b1, 5'd10, 32'd100); tick;
        chk_out("t5_p3", 1, 8, 80);  chk("t5_c_c", 32'(Count_o), 2);
        drive(1'b1, 5'd11, 32'd110); tick;
        chk_out("t5_p4", 1, 9, 90);  chk("t5_c_d", 32'(Count_o), 2);
        drive(1'b0, 5'd0, 32'd0);    tick;
        chk_out("t5_p5", 1, 10, 100);
        tick;
        chk_out("t5_p6", 1, 11, 110);
        chk("t5_c0", 32'(Count_o), 0);
        Drain_En_i = 1'b0;

        // 6. Forwarding
        drive(1'b1, 5'd4, 32'd20); tick;
        drive(1'b1, 5'd4, 32'd99); tick;
        drive(1'b0, 5'd0, 32'd0);
        Fwd_Addr_1_i = 5'd4;
        Fwd_Addr_2_i = 5'd0;
        #1;
        chk("t6_hit1",  32'(Fwd_Hit_1_o), FWD ? 1 : 0);
        chk("t6_data1", Fwd_Data_1_o,     FWD ? 99 : 0);
        chk("t6_hit2",  32'(Fwd_Hit_2_o), 0);
        chk("t6_data2", Fwd_Data_2_o,     0);
        Fwd_Addr_2_i = 5'd9;
        #1;
        chk("t6_miss2", 32'(Fwd_Hit_2_o), 0);
        Drain_En_i = 1'b1;
        tick;
        chk_out("t6_d1", 1, 4, 20);
        chk("t6_newest", Fwd_Data_1_o, FWD ? 99 : 0);
        tick;
        chk_out("t6_d2", 1, 4, 99);
        chk("t6_ostage_hit",  32'(Fwd_Hit_1_o), FWD ? 1 : 0);
        chk("t6_ostage_data", Fwd_Data_1_o,     FWD ? 99 : 0);
        tick;
        chk("t6_gone_hit", 32'(Fwd_Hit_1_o), 0);
        Drain_En_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
